// File: rtl/ls_test_seq.sv
// Sequencer for one lock-and-compare error-counter channel: clears the checker,
// enables the pattern generator, waits for lock, runs a compare window, drains
// the checker pipeline and captures the final error count with a status code.
module ls_test_seq #(
  parameter int unsigned CNT_W     = 12,
  parameter int unsigned WIN_W     = 24,
  parameter int unsigned CLR_CYC   = 4,
  parameter int unsigned LOCK_TO   = 1024,
  parameter int unsigned DRAIN_CYC = 3
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic             ABORT,
  input  logic [WIN_W-1:0] WINDOW_LEN,
  input  logic             CLK_SEL_CFG,
  input  logic             CHK_LOCKED,
  input  logic [CNT_W-1:0] CHK_ERR_CNT,
  output logic             CHK_RST,
  output logic             CHK_CLK_CTRL,
  output logic             RPG_EN,
  output logic             BUSY,
  output logic             DONE,
  output logic [1:0]       STATUS,
  output logic [CNT_W-1:0] RESULT
);

  // One shared counter serves CLEAR, ARM timeout and SETTLE; size it for the longest.
  localparam int unsigned SeqMax =
      (LOCK_TO > CLR_CYC) ? ((LOCK_TO > DRAIN_CYC) ? LOCK_TO : DRAIN_CYC)
                          : ((CLR_CYC > DRAIN_CYC) ? CLR_CYC : DRAIN_CYC);
  localparam int unsigned SeqW = (SeqMax > 1) ? $clog2(SeqMax) : 1;

  localparam logic [1:0] StsOk      = 2'b00;
  localparam logic [1:0] StsTimeout = 2'b01;
  localparam logic [1:0] StsOvf     = 2'b10;
  localparam logic [1:0] StsAbort   = 2'b11;

  typedef enum logic [2:0] {StIdle, StClear, StArm, StRun, StSettle, StCapture} state_e;

  state_e           state;
  logic [SeqW-1:0]  cnt;
  logic [WIN_W-1:0] win_len;
  logic [WIN_W-1:0] win_cnt;
  logic [CNT_W-1:0] prev_cnt;
  logic             ovf;
  logic             timed_out;
  logic             aborted;
  logic             wrap;

  // Error count wrapped from all-ones to zero while the window/drain is active.
  always_comb begin
    wrap = ((state == StRun) || (state == StSettle)) &&
           (CHK_ERR_CNT != prev_cnt) && (CHK_ERR_CNT == '0);
  end

  // Sequencer FSM with registered outputs.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state        <= StIdle;
      cnt          <= '0;
      win_len      <= '0;
      win_cnt      <= '0;
      prev_cnt     <= '0;
      ovf          <= 1'b0;
      timed_out    <= 1'b0;
      aborted      <= 1'b0;
      CHK_RST      <= 1'b1;
      CHK_CLK_CTRL <= 1'b0;
      RPG_EN       <= 1'b0;
      BUSY         <= 1'b0;
      DONE         <= 1'b0;
      STATUS       <= StsOk;
      RESULT       <= '0;
    end else begin
      DONE     <= 1'b0;
      prev_cnt <= CHK_ERR_CNT;
      if (wrap) ovf <= 1'b1;

      unique case (state)
        StIdle: begin
          CHK_RST <= 1'b1;
          RPG_EN  <= 1'b0;
          if (START) begin
            win_len      <= WINDOW_LEN;
            CHK_CLK_CTRL <= CLK_SEL_CFG;
            STATUS       <= StsOk;
            RESULT       <= '0;
            ovf          <= 1'b0;
            timed_out    <= 1'b0;
            aborted      <= 1'b0;
            cnt          <= '0;
            BUSY         <= 1'b1;
            state        <= StClear;
          end
        end

        StClear: begin
          if (ABORT) begin
            aborted <= 1'b1;
            RPG_EN  <= 1'b0;
            state   <= StCapture;
          end else if (cnt == SeqW'(CLR_CYC - 1)) begin
            cnt     <= '0;
            CHK_RST <= 1'b0;
            RPG_EN  <= 1'b1;
            state   <= StArm;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        StArm: begin
          if (ABORT) begin
            aborted <= 1'b1;
            RPG_EN  <= 1'b0;
            state   <= StCapture;
          end else if (CHK_LOCKED) begin
            // Lock beats a coincident timeout; a zero window skips RUN entirely.
            if (win_len == '0) begin
              cnt    <= '0;
              RPG_EN <= 1'b0;
              state  <= StSettle;
            end else begin
              win_cnt <= win_len - WIN_W'(1);
              state   <= StRun;
            end
          end else if (cnt == SeqW'(LOCK_TO - 1)) begin
            timed_out <= 1'b1;
            RPG_EN    <= 1'b0;
            state     <= StCapture;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        StRun: begin
          if (ABORT) begin
            aborted <= 1'b1;
            RPG_EN  <= 1'b0;
            state   <= StCapture;
          end else if (win_cnt == '0) begin
            cnt    <= '0;
            RPG_EN <= 1'b0;
            state  <= StSettle;
          end else begin
            win_cnt <= win_cnt - WIN_W'(1);
          end
        end

        StSettle: begin
          if (ABORT) begin
            aborted <= 1'b1;
            state   <= StCapture;
          end else if (cnt == SeqW'(DRAIN_CYC - 1)) begin
            state <= StCapture;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        StCapture: begin
          if (aborted) begin
            STATUS <= StsAbort;
            RESULT <= CHK_ERR_CNT;
          end else if (timed_out) begin
            STATUS <= StsTimeout;
            RESULT <= CHK_ERR_CNT;
          end else if (ovf) begin
            STATUS <= StsOvf;
            RESULT <= '1;
          end else begin
            STATUS <= StsOk;
            RESULT <= CHK_ERR_CNT;
          end
          DONE    <= 1'b1;
          BUSY    <= 1'b0;
          CHK_RST <= 1'b1;
          RPG_EN  <= 1'b0;
          state   <= StIdle;
        end

        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ls_test_seq.sv
// Scoreboard bench for ls_test_seq: each run plans its checker behaviour, derives
// the expected DONE cycle, status, result and RPG_EN cycle count from the
// sequencing rules, and a monitor compares whenever DONE pulses.
module tb_ls_test_seq;

  localparam int unsigned CNT_W     = 4;
  localparam int unsigned WIN_W     = 12;
  localparam int unsigned CLR_CYC   = 4;
  localparam int unsigned LOCK_TO   = 16;
  localparam int unsigned DRAIN_CYC = 3;
  localparam int          Arm0      = CLR_CYC + 1;  // run-relative cycle ARM begins

  logic             CLK = 1'b0;
  logic             RST_N;
  logic             START;
  logic             ABORT;
  logic [WIN_W-1:0] WINDOW_LEN;
  logic             CLK_SEL_CFG;
  logic             CHK_LOCKED;
  logic [CNT_W-1:0] CHK_ERR_CNT;
  logic             CHK_RST;
  logic             CHK_CLK_CTRL;
  logic             RPG_EN;
  logic             BUSY;
  logic             DONE;
  logic [1:0]       STATUS;
  logic [CNT_W-1:0] RESULT;

  ls_test_seq #(
    .CNT_W    (CNT_W),
    .WIN_W    (WIN_W),
    .CLR_CYC  (CLR_CYC),
    .LOCK_TO  (LOCK_TO),
    .DRAIN_CYC(DRAIN_CYC)
  ) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .START       (START),
    .ABORT       (ABORT),
    .WINDOW_LEN  (WINDOW_LEN),
    .CLK_SEL_CFG (CLK_SEL_CFG),
    .CHK_LOCKED  (CHK_LOCKED),
    .CHK_ERR_CNT (CHK_ERR_CNT),
    .CHK_RST     (CHK_RST),
    .CHK_CLK_CTRL(CHK_CLK_CTRL),
    .RPG_EN      (RPG_EN),
    .BUSY        (BUSY),
    .DONE        (DONE),
    .STATUS      (STATUS),
    .RESULT      (RESULT)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int done_cyc;
    int status;
    int result;
    int clk_ctrl;
    int rpg;
  } exp_t;

  exp_t sb[$];
  exp_t head;
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d cyc=%0d", name, act, exp_v, cyc);
    end
  endtask

  // Monitor: accumulate per-run activity, compare against the scoreboard on DONE.
  int   rpg_acc   = 0;
  int   clr_acc   = 0;
  logic busy_prev = 1'b0;
  always @(negedge CLK) begin
    if (!RST_N) begin
      rpg_acc   = 0;
      clr_acc   = 0;
      busy_prev = 1'b0;
    end else begin
      if (BUSY && !busy_prev) begin
        check("start_status_clear", int'(STATUS), 0);
        check("start_result_clear", int'(RESULT), 0);
        check("start_no_done", int'(DONE), 0);
      end
      if (RPG_EN) rpg_acc++;
      if (CHK_RST && BUSY) clr_acc++;
      if (DONE) begin
        check("done_expected", int'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          head = sb.pop_front();
          check("done_cycle", cyc, head.done_cyc);
          check("status", int'(STATUS), head.status);
          check("result", int'(RESULT), head.result);
          check("clk_ctrl", int'(CHK_CLK_CTRL), head.clk_ctrl);
          check("rpg_en_cycles", rpg_acc, head.rpg);
          check("chk_rst_clear_cycles", clr_acc, int'(CLR_CYC));
          check("busy_at_done", int'(BUSY), 0);
        end
        rpg_acc = 0;
        clr_acc = 0;
      end else if (sb.size() > 0 && cyc > sb[0].done_cyc + 8) begin
        check("done_timeout", cyc, sb[0].done_cyc);
        void'(sb.pop_front());
        rpg_acc = 0;
        clr_acc = 0;
      end
      busy_prev = BUSY;
    end
  end

  task automatic drive_idle(input int k);
    for (int i = 0; i < k; i++) begin
      START       = 1'b0;
      ABORT       = ($urandom_range(0, 3) == 0);  // must be ignored in IDLE
      WINDOW_LEN  = WIN_W'($urandom);
      CLK_SEL_CFG = 1'($urandom);
      CHK_LOCKED  = 1'b0;
      CHK_ERR_CNT = '0;
      @(posedge CLK);
      #1;
    end
    ABORT = 1'b0;
  endtask

  // One run: w window, lock seen d cycles into ARM (d >= LOCK_TO never locks),
  // abort at run-relative cycle ta (0 = none), errors injected in RUN cycles.
  task automatic run(input int w, input int d, input int ta, input int pct, input int emax,
                     input bit cfg);
    int   cap;
    int   run0;
    int   rpg_end;
    int   run_last;
    int   n;
    int   cnt_now;
    bit   lock_ok;
    bit   ab;
    bit   inj[];
    exp_t e;
    lock_ok = (d < int'(LOCK_TO));
    if (lock_ok) begin
      run0    = Arm0 + d + 1;
      rpg_end = run0 + w - 1;
      cap     = run0 + w + int'(DRAIN_CYC);
    end else begin
      run0    = -1;
      rpg_end = Arm0 + int'(LOCK_TO) - 1;
      cap     = Arm0 + int'(LOCK_TO);
    end
    ab = (ta > 0) && (ta < cap);
    if (ab) begin
      cap = ta + 1;
      if (rpg_end > ta) rpg_end = ta;
    end
    run_last = lock_ok ? run0 + w - 1 : -1;
    if (ab && run_last > ta) run_last = ta;
    inj = new[cap + 1];
    n = 0;
    for (int t = 0; t <= cap; t++) begin
      inj[t] = 1'b0;
      if (lock_ok && t >= run0 && t <= run_last && n < emax &&
          int'($urandom_range(0, 99)) < pct) begin
        inj[t] = 1'b1;
        n++;
      end
    end
    e.done_cyc = cyc + cap + 1;
    if (ab)                       e.status = 3;
    else if (!lock_ok)            e.status = 1;
    else if (n >= (1 << CNT_W))   e.status = 2;
    else                          e.status = 0;
    e.result   = (e.status == 2) ? (1 << CNT_W) - 1 : n % (1 << CNT_W);
    e.clk_ctrl = int'(cfg);
    e.rpg      = rpg_end - Arm0 + 1;
    sb.push_back(e);

    cnt_now = 0;
    for (int t = 0; t <= cap; t++) begin
      START       = (t == 0) || ($urandom_range(0, 19) == 0);
      ABORT       = (ta > 0) && (t == ta);
      WINDOW_LEN  = (t == 0) ? WIN_W'(w) : WIN_W'($urandom);
      CLK_SEL_CFG = (t == 0) ? cfg : 1'($urandom);
      CHK_LOCKED  = lock_ok && (t >= Arm0 + d);
      if (inj[t]) cnt_now++;
      CHK_ERR_CNT = CNT_W'(cnt_now);
      @(posedge CLK);
      #1;
    end
    START       = 1'b0;
    ABORT       = 1'b0;
    CHK_LOCKED  = 1'b0;
    CHK_ERR_CNT = '0;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog expired cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int d;
    int cap0;
    int ta;
    RST_N       = 1'b0;
    START       = 1'b1;  // reset must win over START and ABORT
    ABORT       = 1'b1;
    WINDOW_LEN  = '0;
    CLK_SEL_CFG = 1'b1;
    CHK_LOCKED  = 1'b0;
    CHK_ERR_CNT = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_chk_rst", int'(CHK_RST), 1);
    check("rst_rpg_en", int'(RPG_EN), 0);
    check("rst_busy", int'(BUSY), 0);
    check("rst_done", int'(DONE), 0);
    check("rst_status", int'(STATUS), 0);
    check("rst_result", int'(RESULT), 0);
    check("rst_clk_ctrl", int'(CHK_CLK_CTRL), 0);
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    START = 1'b0;
    ABORT = 1'b0;
    drive_idle(2);

    run(100, 5, 0, 50, 7, 1'b1);               // nominal, 7 errors
    drive_idle(3);
    run(20, LOCK_TO + 4, 0, 100, 5, 1'b0);     // lock timeout
    run(40, 2, 0, 100, 17, 1'b1);              // wrap 15->0: overflow, START on DONE cycle
    run(1000, 2, Arm0 + 3 + 50, 100, 3, 1'b0); // abort at RUN cycle 50
    drive_idle(1);
    run(0, 3, 0, 100, 5, 1'b1);                // zero-length window
    run(10, LOCK_TO - 1, 0, 100, 2, 1'b0);     // lock and timeout coincide: lock wins
    run(10, LOCK_TO, 0, 100, 2, 1'b1);         // lock one cycle too late
    run(5, 1, Arm0 + 2 + 5 + DRAIN_CYC, 100, 20, 1'b0);  // abort during CAPTURE ignored
    run(5, 1, Arm0 + 2 + 5 + 1, 100, 20, 1'b1);          // abort during SETTLE
    run(5, 4, Arm0 + 1, 100, 20, 1'b0);                  // abort during ARM
    drive_idle(2);

    for (int i = 0; i < 30; i++) begin
      w    = int'($urandom_range(0, 60));
      d    = int'($urandom_range(0, LOCK_TO + 2));
      cap0 = (d < int'(LOCK_TO)) ? Arm0 + d + 1 + w + int'(DRAIN_CYC) : Arm0 + int'(LOCK_TO);
      ta   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(Arm0, cap0)) : 0;
      run(w, d, ta, int'($urandom_range(0, 100)), int'($urandom_range(0, 40)), 1'($urandom));
      drive_idle(int'($urandom_range(0, 3)));
    end
    drive_idle(12);

    // Reset in the middle of RUN: no DONE may follow.
    START       = 1'b1;
    WINDOW_LEN  = WIN_W'(50);
    CLK_SEL_CFG = 1'b1;
    @(posedge CLK);
    #1;
    START = 1'b0;
    for (int t = 1; t < 15; t++) begin
      CHK_LOCKED = (t >= Arm0);
      @(posedge CLK);
      #1;
    end
    @(negedge CLK);
    check("pre_reset_busy", int'(BUSY), 1);
    check("pre_reset_rpg_en", int'(RPG_EN), 1);
    @(posedge CLK);
    #1;
    RST_N = 1'b0;
    @(posedge CLK);
    #1;
    RST_N      = 1'b1;
    CHK_LOCKED = 1'b0;
    @(negedge CLK);
    check("mid_rst_chk_rst", int'(CHK_RST), 1);
    check("mid_rst_rpg_en", int'(RPG_EN), 0);
    check("mid_rst_busy", int'(BUSY), 0);
    check("mid_rst_done", int'(DONE), 0);
    check("mid_rst_status", int'(STATUS), 0);
    check("mid_rst_result", int'(RESULT), 0);
    check("mid_rst_clk_ctrl", int'(CHK_CLK_CTRL), 0);
    @(posedge CLK);
    #1;
    drive_idle(40);
    check("scoreboard_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ls_test_seq.md
Name: ls_test_seq

Overview:
Sequencer for one lock-and-compare error-counter channel in the chain test. It clears the checker, enables the pattern generator and waits for the checker to lock. It then runs a programmable compare window, drains the checker pipeline and captures the final error count with a status code. It sits between the host register interface and one checker/RPG pair. The checker uses an active-high reset, which this block drives.

Parameters:
CNT_W, 12, width of checker error count and RESULT
WIN_W, 24, width of compare-window length
CLR_CYC, 4, cycles CHK_RST is held high in CLEAR (≥1)
LOCK_TO, 1024, max cycles in ARM waiting for CHK_LOCKED before timeout
DRAIN_CYC, 3, cycles in SETTLE after window end (covers checker compare→count latency)

Ports:
CLK  in  1  system clock; all logic on rising edge
RST_N  in  1  synchronous active-low reset
START  in  1  one-cycle run request; sampled only in IDLE
ABORT  in  1  level; terminates any non-IDLE run
WINDOW_LEN  in  WIN_W  compare window in cycles; latched on accepted START
CLK_SEL_CFG  in  1  crest tap select; latched on accepted START
CHK_LOCKED  in  1  checker compare-start flag (high once aligned)
CHK_ERR_CNT  in  CNT_W  checker running error count
CHK_RST  out  1  active-high reset to checker
CHK_CLK_CTRL  out  1  latched tap select to checker
RPG_EN  out  1  pattern generator enable
BUSY  out  1  high in any state except IDLE
DONE  out  1  one-cycle pulse at run end
STATUS  out  2  00 ok, 01 lock timeout, 10 count overflow, 11 aborted; valid from DONE until next accepted START
RESULT  out  CNT_W  captured error count; valid with STATUS

Behaviour:
- Reset (RST_N=0 at a clock edge) forces IDLE with these values: CHK_RST=1, RPG_EN=0, BUSY=0, DONE=0, STATUS=00, RESULT=0, CHK_CLK_CTRL=0, all internal counters 0. Reset takes priority over ABORT and START.
- States: IDLE, CLEAR, ARM, RUN, SETTLE, CAPTURE.
- IDLE:
  - CHK_RST=1, RPG_EN=0.
  - START=1 latches WINDOW_LEN and CLK_SEL_CFG, clears STATUS/RESULT and the overflow flag, then goes to CLEAR next cycle.
- CLEAR:
  - CHK_RST=1, RPG_EN=0, for exactly CLR_CYC cycles, then go to ARM.
- ARM:
  - CHK_RST=0, RPG_EN=1, timeout counter increments each cycle.
  - CHK_LOCKED=1 goes to RUN (window counter loaded with latched length).
  - Counter reaching LOCK_TO-1 without lock sets STATUS=01 and goes to CAPTURE.
  - If lock and timeout occur in the same cycle, lock wins.
- RUN:
  - RPG_EN=1. Window counter decrements each cycle and stays exactly WINDOW_LEN cycles in RUN, then goes to SETTLE.
  - WINDOW_LEN=0: ARM goes straight to SETTLE on lock (zero-length window).
- SETTLE:
  - RPG_EN=0, CHK_RST=0, for DRAIN_CYC cycles, then go to CAPTURE.
- CAPTURE (1 cycle):
  - RESULT<=CHK_ERR_CNT; DONE=1 on the following cycle while in IDLE.
  - STATUS precedence: aborted > timeout > overflow > ok.
- Overflow detection, active in RUN and SETTLE:
  - Register the previous CHK_ERR_CNT each cycle.
  - If the count changes and the new value is 0 (wrap from all-ones), set a sticky overflow flag.
  - At capture, the flag gives STATUS=10 and RESULT={CNT_W{1'b1}} (saturated).
- ABORT=1 in CLEAR/ARM/RUN/SETTLE: next state CAPTURE with STATUS=11. RESULT still captures CHK_ERR_CNT. RPG_EN drops the same edge. ABORT in IDLE or CAPTURE is ignored.
- START while BUSY is ignored, with no queueing.
- DONE is never asserted in the same cycle as BUSY=1 from a new run. A START on the DONE cycle is accepted.
- All outputs are registered. CHK_RST and RPG_EN change on the state-transition edge.

Test Plan:
- Nominal run: reset, WINDOW_LEN=100, START; CHK_LOCKED rises 5 cycles into ARM; checker injects 7 errors → CHK_RST high exactly 4 cycles, RPG_EN high for lock-wait + 100 cycles, DONE pulses once, STATUS=00, RESULT=7.
- Lock timeout: LOCK_TO=16, CHK_LOCKED held 0 → after 16 ARM cycles DONE pulses with STATUS=01, RESULT=0, RPG_EN low.
- Overflow: CNT_W=4, force CHK_ERR_CNT to walk 13,14,15,0,1 during RUN → STATUS=10, RESULT=4'hF.
- Abort mid-RUN: WINDOW_LEN=1000, ABORT at cycle 50 of RUN with CHK_ERR_CNT=3 → next cycle CAPTURE, RPG_EN=0, then DONE, STATUS=11, RESULT=3.
- Edge cases: WINDOW_LEN=0 → zero RUN cycles, DONE after SETTLE, STATUS=00. START during RUN → ignored and the run completes once. START on the DONE cycle → new run starts and RESULT/STATUS clear.
- Reset mid-run: RST_N=0 for 1 cycle during RUN → next cycle IDLE, CHK_RST=1, RPG_EN=0, BUSY=0, STATUS=00, RESULT=0, no DONE.
